// File: rtl/ila_capture_ctrl_if.sv
// Capture-controller signal bundle: trigger-unit/arm controls in, sample-buffer
// write side and status out. The controller takes the slave view.
interface ila_capture_ctrl_if #(
  parameter int unsigned NTRIG  = 4,
  parameter int unsigned ADDR_W = 10
);
  logic              arm;
  logic              abort;
  logic              reduce_type;
  logic [NTRIG-1:0]  trigger_vec;
  logic              sample_en;
  logic [ADDR_W-1:0] post_count;
  logic              trig_rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              wrapped;
  logic              busy;
  logic              done;

  modport master (
    output arm, abort, reduce_type, trigger_vec, sample_en, post_count,
    input  trig_rst, wr_en, wr_addr, trig_addr, wrapped, busy, done
  );

  modport slave (
    input  arm, abort, reduce_type, trigger_vec, sample_en, post_count,
    output trig_rst, wr_en, wr_addr, trig_addr, wrapped, busy, done
  );
endinterface

// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: reduces trigger bits to one hit, then runs the sample
// buffer through circular pre-trigger and counted post-trigger write phases.
module ila_capture_ctrl #(
  parameter int unsigned NTRIG  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input logic               clk,
  input logic               rst,
  ila_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              wrapped_q, wrapped_d;
  logic              trig_rst_q, trig_rst_d;

  logic [NTRIG-1:0]  tv;
  logic              hit;
  logic              writing;

  assign tv      = bus.trigger_vec;
  assign hit     = bus.reduce_type ? (&tv) : (|tv);
  assign writing = bus.sample_en && !bus.abort && (state_q == ARMED || state_q == POST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      trig_addr_q <= '0;
      remain_q    <= '0;
      wrapped_q   <= 1'b0;
      trig_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trig_addr_q <= trig_addr_d;
      remain_q    <= remain_d;
      wrapped_q   <= wrapped_d;
      trig_rst_q  <= trig_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trig_addr_d = trig_addr_q;
    remain_d    = remain_q;
    wrapped_d   = wrapped_q;
    trig_rst_d  = 1'b0;

    // Address/wrap bookkeeping is shared by ARMED and POST; gated off by abort.
    if (writing) begin
      addr_d = addr_q + ADDR_W'(1);
      if (addr_q == '1) wrapped_d = 1'b1;
    end

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.arm) begin
            state_d    = ARMED;
            trig_rst_d = 1'b1;
            addr_d     = '0;
            wrapped_d  = 1'b0;
            remain_d   = bus.post_count;
          end
        end
        ARMED: begin
          if (bus.sample_en && hit) begin
            trig_addr_d = addr_q;
            state_d     = (remain_q == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (bus.sample_en) begin
            remain_d = remain_q - ADDR_W'(1);
            if (remain_q == ADDR_W'(1)) state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.trig_rst  = trig_rst_q;
  assign bus.wr_en     = writing;
  assign bus.wr_addr   = addr_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.busy      = (state_q == ARMED) || (state_q == POST);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl: expected write addresses and trig_rst
// pulses are queued by the stimulus and consumed by an independent monitor.
module tb_ila_capture_ctrl;

  localparam int unsigned NTRIG  = 4;
  localparam int unsigned ADDR_W = 4;

  logic clk;
  logic rst;

  ila_capture_ctrl_if #(.NTRIG(NTRIG), .ADDR_W(ADDR_W)) bus ();

  ila_capture_ctrl #(.NTRIG(NTRIG), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned wq[$];   // expected write addresses, in order
  int unsigned tq[$];   // expected wr_addr seen during each trig_rst pulse

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got wr_en=1 addr %0d, required wr_en=0 (t=%0t)", bus.wr_addr, $time);
        end else begin
          check("write_addr", int'(bus.wr_addr), wq.pop_front());
        end
      end
      if (bus.trig_rst) begin
        if (tq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_trig_rst: got trig_rst=1, required 0 (t=%0t)", $time);
        end else begin
          check("trig_rst_addr", int'(bus.wr_addr), tq.pop_front());
        end
      end
    end
  end

  task automatic step(input logic a, input logic ab, input logic se, input logic [NTRIG-1:0] v);
    bus.arm         = a;
    bus.abort       = ab;
    bus.sample_en   = se;
    bus.trigger_vec = v;
    @(posedge clk);
    #1;
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    bus.sample_en = 1'b0;
  endtask

  task automatic do_arm(input int unsigned pc);
    bus.post_count = ADDR_W'(pc);
    tq.push_back(0);
    step(1'b1, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic sample(input logic [NTRIG-1:0] v, input int unsigned exp_addr);
    wq.push_back(exp_addr);
    step(1'b0, 1'b0, 1'b1, v);
  endtask

  initial begin
    rst             = 1'b1;
    bus.arm         = 1'b0;
    bus.abort       = 1'b0;
    bus.reduce_type = 1'b0;
    bus.trigger_vec = '0;
    bus.sample_en   = 1'b0;
    bus.post_count  = '0;
    #1;
    check("rst_trig_rst",  bus.trig_rst,  0);
    check("rst_wr_en",     bus.wr_en,     0);
    check("rst_wr_addr",   bus.wr_addr,   0);
    check("rst_trig_addr", bus.trig_addr, 0);
    check("rst_wrapped",   bus.wrapped,   0);
    check("rst_busy",      bus.busy,      0);
    check("rst_done",      bus.done,      0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // OR-reduce, post_count=3, with an ignored arm and a gappy POST phase
    bus.reduce_type = 1'b0;
    do_arm(3);
    check("t1_busy_after_arm", bus.busy, 1);
    sample(4'b0000, 0);
    sample(4'b0000, 1);
    bus.post_count = 4'd9;
    wq.push_back(2);
    step(1'b1, 1'b0, 1'b1, 4'b0000);
    sample(4'b0000, 3);
    sample(4'b0000, 4);
    sample(4'b0010, 5);
    check("t1_trig_addr", bus.trig_addr, 5);
    check("t1_busy_post", bus.busy, 1);
    sample(4'b0000, 6);
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    step(1'b0, 1'b0, 1'b0, 4'b1111);
    check("t1_addr_stall", bus.wr_addr, 7);
    check("t1_not_done_yet", bus.done, 0);
    sample(4'b0000, 7);
    check("t1_done_before_last", bus.done, 0);
    sample(4'b0000, 8);
    check("t1_done", bus.done, 1);
    check("t1_busy_done", bus.busy, 0);
    check("t1_final_addr", bus.wr_addr, 9);
    check("t1_wrapped", bus.wrapped, 0);
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    check("t1_trig_addr_hold", bus.trig_addr, 5);

    // AND-reduce with a partial vector held across a wrap, post_count=0
    bus.reduce_type = 1'b1;
    do_arm(0);
    check("t2_wrapped_cleared", bus.wrapped, 0);
    for (int i = 0; i < 20; i++) begin
      sample(4'b0111, i % 16);
      if (i == 14) check("t2_wrapped_before_16", bus.wrapped, 0);
      if (i == 15) check("t2_wrapped_after_16", bus.wrapped, 1);
    end
    check("t2_still_busy", bus.busy, 1);
    sample(4'b1111, 4);
    check("t2_trig_addr", bus.trig_addr, 4);
    check("t2_done", bus.done, 1);
    check("t2_wrapped_hold", bus.wrapped, 1);

    // post_count=0 with a hit on the very first sample
    bus.reduce_type = 1'b0;
    do_arm(0);
    sample(4'b0001, 0);
    check("t3_trig_addr", bus.trig_addr, 0);
    check("t3_done", bus.done, 1);
    check("t3_wrapped", bus.wrapped, 0);
    step(1'b0, 1'b0, 1'b1, 4'b0001);
    check("t3_one_write_addr", bus.wr_addr, 1);

    // Abort together with arm in POST, two samples still outstanding
    do_arm(4);
    sample(4'b1000, 0);
    sample(4'b0000, 1);
    sample(4'b0000, 2);
    step(1'b1, 1'b1, 1'b1, 4'b0000);
    check("t4_idle_busy", bus.busy, 0);
    check("t4_idle_done", bus.done, 0);
    check("t4_trig_addr_hold", bus.trig_addr, 0);
    check("t4_addr_hold", bus.wr_addr, 3);
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    do_arm(0);
    check("t4_rearm_addr", bus.wr_addr, 0);
    sample(4'b0100, 0);
    check("t4_rearm_done", bus.done, 1);

    // Asynchronous reset in the middle of POST
    do_arm(5);
    sample(4'b0010, 0);
    sample(4'b0000, 1);
    bus.sample_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t5_wr_en", bus.wr_en, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_wr_addr", bus.wr_addr, 0);
    check("t5_trig_addr", bus.trig_addr, 0);
    check("t5_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'b1111);
    check("t5_idle_addr", bus.wr_addr, 0);

    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    check("writes_pending", wq.size(), 0);
    check("trig_rst_pending", tq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
